// File: rtl/coin_report_streamer_if.sv
// Byte-stream valid/ready link from the coin report streamer to the UART transmitter.
interface coin_report_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/coin_report_streamer.sv
// Snapshots per-channel coin counts on start and streams an ASCII report frame
// ("<denom>baht <count> ... \n\r") one byte per accepted handshake.
module coin_report_streamer #(
  parameter int                  NUM_CH = 4,
  parameter int                  CNT_W  = 10,
  parameter int                  DIGITS = 3,
  parameter logic [NUM_CH*8-1:0] DENOMS = {8'd10, 8'd5, 8'd2, 8'd1}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_CH*CNT_W-1:0]   counts,
  coin_report_streamer_if.master    tx,
  output logic                      busy,
  output logic                      done
);

  localparam int              BCD_W   = 4 * DIGITS;
  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int              MAXV    = 10**DIGITS - 1;
  localparam logic [7:0]      TOP_DEN = DENOMS[NUM_CH*8-1 -: 8];
  localparam logic [CH_W-1:0] TOP_CH  = CH_W'(NUM_CH - 1);
  localparam logic [4:0]      CYC_END = 5'(CNT_W - 1);

  typedef enum logic [2:0] {IDLE, LABEL, CONV, DIGIT, TAIL} state_t;

  state_t            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [2:0]        idx_q;
  logic [4:0]        cyc_q;
  logic [CNT_W-1:0]  snap_q [NUM_CH];
  logic [CNT_W-1:0]  bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [BCD_W-1:0]  bcd_d;
  logic [CNT_W-1:0]  bin_d;
  logic [CH_W-1:0]   ch_d;
  logic [7:0]        cur_den;
  logic [7:0]        nxt_den;
  logic              accept;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return (32'(c) > 32'(MAXV)) ? CNT_W'(MAXV) : c;
  endfunction

  function automatic logic [2:0] label_last(input logic [7:0] d);
    return (d >= 8'd10) ? 3'd6 : 3'd5;
  endfunction

  // Label = optional tens digit, ones digit, then "baht ".
  function automatic logic [7:0] label_byte(input logic [7:0] d, input logic [2:0] idx);
    logic [7:0] b;
    logic [2:0] k;
    logic       two;
    two = (d >= 8'd10);
    k   = two ? idx - 3'd2 : idx - 3'd1;
    case (k)
      3'd0:    b = 8'h62;
      3'd1:    b = 8'h61;
      3'd2:    b = 8'h68;
      3'd3:    b = 8'h74;
      default: b = 8'h20;
    endcase
    if (two && idx == 3'd0)                 b = 8'h30 + d / 8'd10;
    else if (idx == (two ? 3'd1 : 3'd0))    b = 8'h30 + d % 8'd10;
    return b;
  endfunction

  // Saturated values fit in DIGITS nibbles, so bits shifted past the top are always zero.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd, input logic msb);
    logic [BCD_W-1:0] a;
    a = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return {a[BCD_W-2:0], msb};
  endfunction

  function automatic logic [7:0] digit_char(input logic [BCD_W-1:0] bcd, input int k);
    return 8'h30 + {4'h0, bcd[4*(DIGITS-1-k) +: 4]};
  endfunction

  assign bcd_d   = dd_step(bcd_q, bin_q[CNT_W-1]);
  assign bin_d   = {bin_q[CNT_W-2:0], 1'b0};
  assign ch_d    = ch_q - CH_W'(1);
  assign cur_den = DENOMS[{ch_q, 3'b000} +: 8];
  assign nxt_den = DENOMS[{ch_d, 3'b000} +: 8];
  assign accept  = tx_valid_q && tx.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      idx_q      <= '0;
      cyc_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          for (int i = 0; i < NUM_CH; i++) snap_q[i] <= sat(counts[CNT_W*i +: CNT_W]);
          ch_q       <= TOP_CH;
          idx_q      <= '0;
          tx_data_q  <= label_byte(TOP_DEN, 3'd0);
          tx_valid_q <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= LABEL;
        end
        LABEL: if (accept) begin
          if (idx_q == label_last(cur_den)) begin
            tx_valid_q <= 1'b0;
            bin_q      <= snap_q[ch_q];
            bcd_q      <= '0;
            cyc_q      <= '0;
            state_q    <= CONV;
          end else begin
            idx_q     <= idx_q + 3'd1;
            tx_data_q <= label_byte(cur_den, idx_q + 3'd1);
          end
        end
        // The final shift step also presents the first digit from the new BCD value.
        CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          if (cyc_q == CYC_END) begin
            idx_q      <= '0;
            tx_data_q  <= digit_char(bcd_d, 0);
            tx_valid_q <= 1'b1;
            state_q    <= DIGIT;
          end else begin
            cyc_q <= cyc_q + 5'd1;
          end
        end
        // idx_q == DIGITS is the separator slot between channels.
        DIGIT: if (accept) begin
          if (int'(idx_q) == DIGITS) begin
            ch_q      <= ch_d;
            idx_q     <= '0;
            tx_data_q <= label_byte(nxt_den, 3'd0);
            state_q   <= LABEL;
          end else if (int'(idx_q) == DIGITS - 1) begin
            if (ch_q == '0) begin
              idx_q     <= '0;
              tx_data_q <= 8'h0A;
              state_q   <= TAIL;
            end else begin
              idx_q     <= idx_q + 3'd1;
              tx_data_q <= 8'h20;
            end
          end else begin
            idx_q     <= idx_q + 3'd1;
            tx_data_q <= digit_char(bcd_q, int'(idx_q) + 1);
          end
        end
        TAIL: if (accept) begin
          if (idx_q == 3'd0) begin
            idx_q     <= 3'd1;
            tx_data_q <= 8'h0D;
          end else begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_coin_report_streamer.sv
// Directed + randomized bench for coin_report_streamer: default 4-channel instance
// and a 1-channel / 2-digit / 7-bit variant, both checked against a string-level report model.
module tb_coin_report_streamer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1;
  logic [39:0] counts0;
  logic [6:0]  counts1;
  logic        busy0, done0, busy1, done1;

  coin_report_streamer_if if0 ();
  coin_report_streamer_if if1 ();

  coin_report_streamer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .counts(counts0),
    .tx(if0), .busy(busy0), .done(done0)
  );

  coin_report_streamer #(.NUM_CH(1), .CNT_W(7), .DIGITS(2), .DENOMS(8'd5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .counts(counts1),
    .tx(if1), .busy(busy1), .done(done1)
  );

  int compared, mismatched;
  int DEN0 [8] = '{1, 2, 5, 10, 0, 0, 0, 0};
  int DEN1 [8] = '{5, 0, 0, 0, 0, 0, 0, 0};

  // Monitors: capture accepted bytes, CONV gap lengths, done pulses, stall stability.
  logic       clr_req;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         gaps0 [$];
  int         gaps1 [$];
  int         ndone0, nstab0, run0, ndone1, run1;
  logic       stall0;
  logic [7:0] hold0;

  always @(negedge clk) begin
    if (clr_req) begin
      q0.delete(); gaps0.delete();
      ndone0 <= 0; nstab0 <= 0; run0 <= 0; stall0 <= 1'b0;
    end else if (!rst_n) begin
      run0 <= 0; stall0 <= 1'b0;
    end else begin
      if (stall0 && (if0.tx_valid !== 1'b1 || if0.tx_data !== hold0)) nstab0 <= nstab0 + 1;
      stall0 <= if0.tx_valid && !if0.tx_ready;
      hold0  <= if0.tx_data;
      if (if0.tx_valid && if0.tx_ready) q0.push_back(if0.tx_data);
      if (busy0 && !if0.tx_valid) run0 <= run0 + 1;
      else if (run0 != 0) begin gaps0.push_back(run0); run0 <= 0; end
      if (done0) ndone0 <= ndone0 + 1;
    end
  end

  always @(negedge clk) begin
    if (clr_req) begin
      q1.delete(); gaps1.delete();
      ndone1 <= 0; run1 <= 0;
    end else if (!rst_n) begin
      run1 <= 0;
    end else begin
      if (if1.tx_valid && if1.tx_ready) q1.push_back(if1.tx_data);
      if (busy1 && !if1.tx_valid) run1 <= run1 + 1;
      else if (run1 != 0) begin gaps1.push_back(run1); run1 <= 0; end
      if (done1) ndone1 <= ndone1 + 1;
    end
  end

  // Reference: the report frame as text, built straight from the frame rules.
  function automatic string model(input int nch, input int digits, input int den[8], input int cnt[8]);
    string s, t;
    int    maxv, v;
    maxv = 10**digits - 1;
    s = "";
    for (int c = nch - 1; c >= 0; c--) begin
      v = (cnt[c] > maxv) ? maxv : cnt[c];
      t = $sformatf("%0d", v);
      while (t.len() < digits) t = {"0", t};
      s = {s, $sformatf("%0dbaht ", den[c]), t};
      if (c != 0) s = {s, " "};
    end
    return {s, $sformatf("%c%c", 8'h0A, 8'h0D)};
  endfunction

  function automatic string qstr(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%c", q[i])};
    return s;
  endfunction

  function automatic string pr(input string s);
    string r = "";
    byte   b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      if (b == 8'h0A)      r = {r, "<LF>"};
      else if (b == 8'h0D) r = {r, "<CR>"};
      else                 r = {r, $sformatf("%c", b)};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    compared++;
    assert (obs == exp) else begin
      mismatched++;
      $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, pr(obs), pr(exp));
    end
  endtask

  task automatic clr();
    @(posedge clk); #1 clr_req = 1'b1;
    @(negedge clk); #1 clr_req = 1'b0;
  endtask

  // One frame on the default instance; optional random backpressure and mid-frame poke.
  task automatic frame0(input int c[8], input bit rnd, input bit poke, input string tag, output string got);
    string exp;
    bit    seen;
    int    ps;
    exp = model(4, 3, DEN0, c);
    clr();
    counts0 = {10'(c[3]), 10'(c[2]), 10'(c[1]), 10'(c[0])};
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk({tag, ":busy@t+1"},  busy0, 1);
    chk({tag, ":valid@t+1"}, if0.tx_valid, 1);
    chk({tag, ":byte0"},     if0.tx_data, exp[0]);
    seen = 1'b0;
    ps = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      if (rnd) if0.tx_ready = ($urandom_range(0, 99) < 40);
      if (ps == 1) begin counts0 = {4{10'd500}}; start0 = 1'b1; ps = 2; end
      else if (ps == 2) begin start0 = 1'b0; ps = 3; end
      @(negedge clk); #1;
      if (poke && ps == 0 && q0.size() >= 5) ps = 1;
      if (done0) seen = 1'b1;
    end
    chk({tag, ":done_seen"},  seen, 1);
    chk({tag, ":busy@done"},  busy0, 0);
    chk({tag, ":valid@done"}, if0.tx_valid, 0);
    if0.tx_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ":done_1cyc"}, done0, 0);
    got = qstr(q0);
    chk_s({tag, ":frame"}, got, exp);
    chk({tag, ":nbytes"}, q0.size(), exp.len());
    chk({tag, ":ndone"}, ndone0, 1);
    chk({tag, ":stable"}, nstab0, 0);
    chk({tag, ":ngaps"}, gaps0.size(), 4);
    foreach (gaps0[k]) chk({tag, $sformatf(":gap%0d", k)}, gaps0[k], 10);
  endtask

  task automatic frame1(input int cnt, input string tag, output string got);
    string exp;
    bit    seen;
    int    c1 [8];
    c1 = '{0, 0, 0, 0, 0, 0, 0, 0};
    c1[0] = cnt;
    exp = model(1, 2, DEN1, c1);
    clr();
    counts1 = 7'(cnt);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk({tag, ":busy@t+1"},  busy1, 1);
    chk({tag, ":valid@t+1"}, if1.tx_valid, 1);
    chk({tag, ":byte0"},     if1.tx_data, exp[0]);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk); #1;
      if (done1) seen = 1'b1;
    end
    chk({tag, ":done_seen"},  seen, 1);
    chk({tag, ":busy@done"},  busy1, 0);
    chk({tag, ":valid@done"}, if1.tx_valid, 0);
    @(posedge clk); #1;
    got = qstr(q1);
    chk_s({tag, ":frame"}, got, exp);
    chk({tag, ":ndone"}, ndone1, 1);
    chk({tag, ":ngaps"}, gaps1.size(), 1);
    foreach (gaps1[k]) chk({tag, ":gap"}, gaps1[k], 7);
  endtask

  int    c [8];
  string got, base, ref_s, lfcr;
  bit    seen;

  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; counts0 = '0; counts1 = '0;
    if0.tx_ready = 1'b1; if1.tx_ready = 1'b1; clr_req = 1'b0;
    lfcr = $sformatf("%c%c", 8'h0A, 8'h0D);

    repeat (3) @(posedge clk);
    #1;
    chk("rst:valid", if0.tx_valid, 0);
    chk("rst:data",  if0.tx_data, 0);
    chk("rst:busy",  busy0, 0);
    chk("rst:done",  done0, 0);
    chk("rst:valid1", if1.tx_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    c = '{999, 0, 123, 7, 0, 0, 0, 0};
    frame0(c, 1'b0, 1'b0, "base", got);
    chk_s("base:literal", got, {"10baht 007 5baht 123 2baht 000 1baht 999", lfcr});
    chk("base:len42", q0.size(), 42);
    base = got;

    c = '{1023, 5, 5, 5, 0, 0, 0, 0};
    frame0(c, 1'b0, 1'b0, "sat", got);
    chk_s("sat:literal", got, {"10baht 005 5baht 005 2baht 005 1baht 999", lfcr});

    c = '{4, 3, 2, 1, 0, 0, 0, 0};
    frame0(c, 1'b0, 1'b0, "bp_ref", ref_s);
    frame0(c, 1'b1, 1'b0, "bp", got);
    chk_s("bp:same_as_ready1", got, ref_s);

    for (int r = 0; r < 3; r++) begin
      c = '{0, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 1023));
      frame0(c, 1'b1, 1'b0, $sformatf("rand%0d", r), got);
    end

    c = '{999, 0, 123, 7, 0, 0, 0, 0};
    frame0(c, 1'b0, 1'b1, "snap", got);
    chk_s("snap:orig_counts", got, base);
    repeat (60) @(posedge clk);
    #1;
    chk("snap:idle_busy", busy0, 0);
    chk("snap:no_2nd_frame", q0.size(), 42);
    chk("snap:ndone_after", ndone0, 1);

    clr();
    counts0 = {10'd7, 10'd123, 10'd0, 10'd999};
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk); #1;
      if (q0.size() >= 20) seen = 1'b1;
    end
    chk("rst_mid:reach20", seen, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid:valid", if0.tx_valid, 0);
    chk("rst_mid:busy",  busy0, 0);
    chk("rst_mid:done",  done0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid:busy_after",  busy0, 0);
    chk("rst_mid:valid_after", if0.tx_valid, 0);
    chk("rst_mid:no_done",     ndone0, 0);
    chk("rst_mid:bytes",       q0.size(), 20);
    c = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 1023));
    frame0(c, 1'b0, 1'b0, "rst_recover", got);

    frame1(42, "var42", got);
    chk_s("var42:literal", got, {"5baht 42", lfcr});
    chk("var42:len10", q1.size(), 10);
    frame1(int'($urandom_range(0, 127)), "var_rand", got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
